// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory bank between instruction fetch and data access,
// with data priority and a bounded data streak. Optional BUSY abort: ARB_TIMEOUT_EN.
//
// state     | meaning
// S_IDLE    | arbitrate pending requests, latch winner onto mem_* registers
// S_BUSY_IF | fetch access in flight, waiting for mem_ready
// S_BUSY_DM | data access in flight, waiting for mem_ready
// S_RESP    | one-cycle ack to the served requester
module mem_port_arbiter #(
   parameter int AW         = 8,
   parameter int DW         = 32,
   parameter int MAX_STREAK = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_if_req,
   input  logic [AW-1:0] i_if_addr,
   output logic          o_if_ack,
   output logic [DW-1:0] o_if_rdata,
   input  logic          i_dm_req,
   input  logic          i_dm_we,
   input  logic [AW-1:0] i_dm_addr,
   input  logic [DW-1:0] i_dm_wdata,
   output logic          o_dm_ack,
   output logic [DW-1:0] o_dm_rdata,
   output logic          o_stall_if,
   output logic          o_stall_mem,
   output logic          o_mem_en,
   output logic          o_mem_we,
   output logic [AW-1:0] o_mem_addr,
   output logic [DW-1:0] o_mem_wdata,
   input  logic [DW-1:0] i_mem_rdata,
   input  logic          i_mem_ready,
   output logic          o_timeout_err
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY_IF, S_BUSY_DM, S_RESP} state_t;

   localparam logic [3:0] LP_MAX_STREAK = 4'(MAX_STREAK);

   state_t          r_state;
   logic [3:0]      r_streak;
   logic            r_mem_en;
   logic            r_mem_we;
   logic [AW-1:0]   r_mem_addr;
   logic [DW-1:0]   r_mem_wdata;
   logic [DW-1:0]   r_if_rdata;
   logic [DW-1:0]   r_dm_rdata;
   logic            r_if_ack;
   logic            r_dm_ack;
   logic            w_dm_win;

`ifdef ARB_TIMEOUT_EN
   localparam logic [7:0] LP_WAIT_LOAD = 8'(TIMEOUT - 1);
   logic [7:0]      r_wait;
   logic            r_timeout_err;
   assign o_timeout_err = r_timeout_err;
`else
   localparam int unused_timeout = TIMEOUT;
   assign o_timeout_err = 1'b0;
`endif

   // Fetch overrides data only once data has won MAX_STREAK times in a row over a waiting fetch.
   assign w_dm_win = i_dm_req & ~(i_if_req & (r_streak == LP_MAX_STREAK));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state       <= S_IDLE;
         r_streak      <= 4'd0;
         r_mem_en      <= 1'b0;
         r_mem_we      <= 1'b0;
         r_mem_addr    <= '0;
         r_mem_wdata   <= '0;
         r_if_rdata    <= '0;
         r_dm_rdata    <= '0;
         r_if_ack      <= 1'b0;
         r_dm_ack      <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         r_wait        <= 8'd0;
         r_timeout_err <= 1'b0;
`endif
      end else begin
         r_if_ack <= 1'b0;
         r_dm_ack <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_dm_win) begin
                  r_mem_en    <= 1'b1;
                  r_mem_we    <= i_dm_we;
                  r_mem_addr  <= i_dm_addr;
                  r_mem_wdata <= i_dm_wdata;
                  r_streak    <= i_if_req ? r_streak + 4'd1 : 4'd0;
                  r_state     <= S_BUSY_DM;
`ifdef ARB_TIMEOUT_EN
                  r_wait      <= LP_WAIT_LOAD;
`endif
               end else if (i_if_req) begin
                  r_mem_en    <= 1'b1;
                  r_mem_we    <= 1'b0;
                  r_mem_addr  <= i_if_addr;
                  r_streak    <= 4'd0;
                  r_state     <= S_BUSY_IF;
`ifdef ARB_TIMEOUT_EN
                  r_wait      <= LP_WAIT_LOAD;
`endif
               end
            end
            S_BUSY_IF, S_BUSY_DM: begin
               if (i_mem_ready) begin
                  r_mem_en <= 1'b0;
                  r_mem_we <= 1'b0;
                  r_state  <= S_RESP;
                  if (r_state == S_BUSY_DM) begin
                     r_dm_rdata <= i_mem_rdata;
                     r_dm_ack   <= 1'b1;
                  end else begin
                     r_if_rdata <= i_mem_rdata;
                     r_if_ack   <= 1'b1;
                  end
               end
`ifdef ARB_TIMEOUT_EN
               // Down-counter reaching zero marks the TIMEOUT-th cycle without mem_ready.
               else if (r_wait == 8'd0) begin
                  r_mem_en      <= 1'b0;
                  r_mem_we      <= 1'b0;
                  r_state       <= S_RESP;
                  r_timeout_err <= 1'b1;
                  if (r_state == S_BUSY_DM) begin
                     r_dm_rdata <= '0;
                     r_dm_ack   <= 1'b1;
                  end else begin
                     r_if_rdata <= '0;
                     r_if_ack   <= 1'b1;
                  end
               end else begin
                  r_wait <= r_wait - 8'd1;
               end
`endif
            end
            S_RESP: r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_if_ack    = r_if_ack;
   assign o_if_rdata  = r_if_rdata;
   assign o_dm_ack    = r_dm_ack;
   assign o_dm_rdata  = r_dm_rdata;
   assign o_mem_en    = r_mem_en;
   assign o_mem_we    = r_mem_we;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_wdata = r_mem_wdata;
   assign o_stall_if  = i_if_req & ~r_if_ack;
   assign o_stall_mem = i_dm_req & ~r_dm_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: bench-side memory responder with configurable
// wait states, per-port expected-data queues, and cycle-exact timing checks.
module tb_mem_port_arbiter;
   localparam int AW = 8;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_if_req = 1'b0;
   logic [AW-1:0] i_if_addr = '0;
   logic          o_if_ack;
   logic [DW-1:0] o_if_rdata;
   logic          i_dm_req = 1'b0;
   logic          i_dm_we = 1'b0;
   logic [AW-1:0] i_dm_addr = '0;
   logic [DW-1:0] i_dm_wdata = '0;
   logic          o_dm_ack;
   logic [DW-1:0] o_dm_rdata;
   logic          o_stall_if;
   logic          o_stall_mem;
   logic          o_mem_en;
   logic          o_mem_we;
   logic [AW-1:0] o_mem_addr;
   logic [DW-1:0] o_mem_wdata;
   logic [DW-1:0] i_mem_rdata = '0;
   logic          i_mem_ready = 1'b0;
   logic          o_timeout_err;

   mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_STREAK(4), .TIMEOUT(16)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_ack(o_if_ack), .o_if_rdata(o_if_rdata),
      .i_dm_req(i_dm_req), .i_dm_we(i_dm_we), .i_dm_addr(i_dm_addr), .i_dm_wdata(i_dm_wdata),
      .o_dm_ack(o_dm_ack), .o_dm_rdata(o_dm_rdata),
      .o_stall_if(o_stall_if), .o_stall_mem(o_stall_mem),
      .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
      .i_mem_rdata(i_mem_rdata), .i_mem_ready(i_mem_ready), .o_timeout_err(o_timeout_err)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] mem [256];
   int            wait_cfg = 0;
   int            rsp_cnt = 0;
   int            errors = 0;
   int            checks = 0;
   logic [DW-1:0] if_q[$];
   logic [DW-1:0] dm_q[$];
   string         grant_str = "";
   bit            log_en = 1'b0;
   logic          prev_en = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Memory bank model: ready after wait_cfg busy cycles, read data is pre-write contents.
   always @(posedge clk) begin
      #1;
      if (o_mem_en) begin
         i_mem_rdata = mem[o_mem_addr];
         if (rsp_cnt == wait_cfg) begin
            i_mem_ready = 1'b1;
            rsp_cnt = 0;
            if (o_mem_we) mem[o_mem_addr] = o_mem_wdata;
         end else begin
            i_mem_ready = 1'b0;
            rsp_cnt++;
         end
      end else begin
         i_mem_ready = 1'b0;
         i_mem_rdata = '0;
         rsp_cnt = 0;
      end
   end

   always @(posedge clk) begin
      #1;
      if (log_en && o_mem_en && !prev_en)
         grant_str = {grant_str, (o_mem_addr >= 8'h40) ? "D" : "F"};
      prev_en = o_mem_en;
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (o_if_ack) begin
            if (if_q.size() == 0) begin
               checks++;
               errors++;
               $error("FAIL if_ack_unexpected: got ack with rdata 0x%0h, expected no ack", o_if_rdata);
            end else check("if_rdata", o_if_rdata, if_q.pop_front());
         end
         if (o_dm_ack) begin
            if (dm_q.size() == 0) begin
               checks++;
               errors++;
               $error("FAIL dm_ack_unexpected: got ack with rdata 0x%0h, expected no ack", o_dm_rdata);
            end else check("dm_rdata", o_dm_rdata, dm_q.pop_front());
         end
      end
   end

   task automatic issue_dm(input logic [7:0] a, input logic we, input logic [31:0] wd);
      bit seen = 1'b0;
      dm_q.push_back(mem[a]);
      i_dm_req = 1'b1; i_dm_we = we; i_dm_addr = a; i_dm_wdata = wd;
      for (int n = 0; n < 64; n++) begin
         step();
         if (o_dm_ack) begin seen = 1'b1; break; end
      end
      check("dm_ack_seen", 32'(seen), 32'd1);
      step();
      i_dm_req = 1'b0;
   endtask

   task automatic issue_if(input logic [7:0] a);
      bit seen = 1'b0;
      if_q.push_back(mem[a]);
      i_if_req = 1'b1; i_if_addr = a;
      for (int n = 0; n < 64; n++) begin
         step();
         if (o_if_ack) begin seen = 1'b1; break; end
      end
      check("if_ack_seen", 32'(seen), 32'd1);
      step();
      i_if_req = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 + 32'(i) * 32'h0001_0101;

      step();
      step();
      check("rst_mem_en", o_mem_en, 0);
      check("rst_mem_addr", o_mem_addr, 0);
      check("rst_if_ack", o_if_ack, 0);
      check("rst_dm_rdata", o_dm_rdata, 0);
      check("rst_timeout_err", o_timeout_err, 0);
      rst = 1'b0;
      step();

      // single zero-wait fetch
      mem[8'h10] = 32'hDEADBEEF;
      if_q.push_back(32'hDEADBEEF);
      i_if_req = 1'b1; i_if_addr = 8'h10;
      #1;
      check("f_c0_stall_if", o_stall_if, 1);
      check("f_c0_mem_en", o_mem_en, 0);
      step();
      check("f_c1_mem_en", o_mem_en, 1);
      check("f_c1_mem_addr", o_mem_addr, 32'h10);
      check("f_c1_mem_we", o_mem_we, 0);
      check("f_c1_stall_if", o_stall_if, 1);
      check("f_c1_if_ack", o_if_ack, 0);
      step();
      check("f_c2_if_ack", o_if_ack, 1);
      check("f_c2_if_rdata", o_if_rdata, 32'hDEADBEEF);
      check("f_c2_stall_if", o_stall_if, 0);
      check("f_c2_mem_en", o_mem_en, 0);
      step();
      i_if_req = 1'b0;
      check("f_c3_if_ack", o_if_ack, 0);

      // collision: data write wins, fetch granted in the IDLE cycle after ack
      dm_q.push_back(mem[8'h20]);
      if_q.push_back(mem[8'h24]);
      i_dm_req = 1'b1; i_dm_we = 1'b1; i_dm_addr = 8'h20; i_dm_wdata = 32'h12345678;
      i_if_req = 1'b1; i_if_addr = 8'h24;
      step();
      check("c_c1_mem_en", o_mem_en, 1);
      check("c_c1_mem_we", o_mem_we, 1);
      check("c_c1_mem_addr", o_mem_addr, 32'h20);
      check("c_c1_mem_wdata", o_mem_wdata, 32'h12345678);
      check("c_c1_stall_mem", o_stall_mem, 1);
      step();
      check("c_c2_dm_ack", o_dm_ack, 1);
      check("c_c2_stall_mem", o_stall_mem, 0);
      check("c_c2_stall_if", o_stall_if, 1);
      check("c_c2_if_ack", o_if_ack, 0);
      step();
      i_dm_req = 1'b0; i_dm_we = 1'b0;
      check("c_c3_mem_en", o_mem_en, 0);
      step();
      check("c_c4_mem_en", o_mem_en, 1);
      check("c_c4_mem_addr", o_mem_addr, 32'h24);
      check("c_c4_mem_we", o_mem_we, 0);
      step();
      check("c_c5_if_ack", o_if_ack, 1);
      step();
      i_if_req = 1'b0;
      check("c_mem_written", mem[8'h20], 32'h12345678);

      // starvation bound: four data grants, then fetch, then streak restarts
      log_en = 1'b1;
      fork
         begin
            for (int k = 0; k < 5; k++) issue_dm(8'(8'h40 + k), 1'b0, 32'h0);
         end
         begin
            issue_if(8'h30);
            issue_if(8'h34);
         end
      join
      log_en = 1'b0;
      checks++;
      assert (grant_str == "DDDDFDF") else begin
         errors++;
         $error("FAIL grant_order: got %s expected DDDDFDF", grant_str);
      end

      // five wait states: mem_* held stable, ack 7 cycles after request
      wait_cfg = 5;
      step();
      dm_q.push_back(mem[8'h50]);
      i_dm_req = 1'b1; i_dm_we = 1'b1; i_dm_addr = 8'h50; i_dm_wdata = 32'hCAFEF00D;
      step();
      for (int c = 1; c <= 6; c++) begin
         check("ws_mem_en", o_mem_en, 1);
         check("ws_mem_addr", o_mem_addr, 32'h50);
         check("ws_mem_we", o_mem_we, 1);
         check("ws_mem_wdata", o_mem_wdata, 32'hCAFEF00D);
         check("ws_dm_ack_early", o_dm_ack, 0);
         step();
      end
      check("ws_c7_dm_ack", o_dm_ack, 1);
      step();
      i_dm_req = 1'b0; i_dm_we = 1'b0;
      check("ws_mem_written", mem[8'h50], 32'hCAFEF00D);

      // asynchronous reset in the middle of a data access
      step();
      dm_q.push_back(mem[8'h70]);
      i_dm_req = 1'b1; i_dm_addr = 8'h70;
      step();
      check("r_c1_mem_en", o_mem_en, 1);
      #2;
      rst = 1'b1;
      #1;
      check("r_async_mem_en", o_mem_en, 0);
      check("r_async_dm_ack", o_dm_ack, 0);
      check("r_async_timeout_err", o_timeout_err, 0);
      i_dm_req = 1'b0;
      dm_q.delete();
      step();
      step();
      rst = 1'b0;
      wait_cfg = 0;
      step();
      check("r_after_mem_en", o_mem_en, 0);
      check("r_after_dm_ack", o_dm_ack, 0);
      issue_dm(8'h74, 1'b0, 32'h0);

`ifdef ARB_TIMEOUT_EN
      begin
         int n;
         n = 0;
         wait_cfg = 1000;
         dm_q.push_back(32'h0);
         i_dm_req = 1'b1; i_dm_we = 1'b0; i_dm_addr = 8'h60;
         while (n < 40) begin
            step();
            n++;
            if (o_dm_ack) break;
         end
         check("to_ack_cycle", n, 17);
         check("to_dm_rdata", o_dm_rdata, 0);
         check("to_mem_en", o_mem_en, 0);
         check("to_err_set", o_timeout_err, 1);
         step();
         i_dm_req = 1'b0;
         wait_cfg = 0;
         issue_if(8'h64);
         check("to_err_sticky", o_timeout_err, 1);
      end
`else
      check("no_timeout_err", o_timeout_err, 0);
`endif

      step();
      step();
      check("if_q_drained", if_q.size(), 0);
      check("dm_q_drained", dm_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
